// File: rtl/aes_pkg.sv
// Shared definitions for the memory-mapped AES unit.
//   - XRAM register map of the AES unit (key bytes, op, state, opaddr, oplen)
//   - op encodings and STATE field encodings read back by firmware
//   - local encodings of the DMA sequencer FSM
package aes_pkg;

  localparam int unsigned AES_BLK_BYTES = 16;

  // Register map.
  localparam logic [15:0] AES_REG_KEY00  = 16'hff00;
  localparam logic [15:0] AES_REG_KEY01  = 16'hff02;
  localparam logic [15:0] AES_REG_KEY02  = 16'hff04;
  localparam logic [15:0] AES_REG_KEY03  = 16'hff06;
  localparam logic [15:0] AES_REG_KEY04  = 16'hff08;
  localparam logic [15:0] AES_REG_KEY05  = 16'hff0a;
  localparam logic [15:0] AES_REG_KEY06  = 16'hff0c;
  localparam logic [15:0] AES_REG_KEY07  = 16'hff0e;
  localparam logic [15:0] AES_REG_OP     = 16'hff80;
  localparam logic [15:0] AES_REG_STATE  = 16'hff82;
  localparam logic [15:0] AES_REG_OPADDR = 16'hff84;
  localparam logic [15:0] AES_REG_OPLEN  = 16'hff86;

  // Operation direction.
  localparam logic AES_OP_ENCRYPT = 1'b0;
  localparam logic AES_OP_DECRYPT = 1'b1;

  // STATE register field.
  localparam logic [1:0] AES_STATE_IDLE       = 2'd0;
  localparam logic [1:0] AES_STATE_ENCRYPTING = 2'd1;
  localparam logic [1:0] AES_STATE_DECRYPTING = 2'd2;

  // DMA sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCrypt,
    StWr,
    StFin
  } aes_dma_st_e;

  // STATE field value for a given sequencer state and latched op.
  function automatic logic [1:0] aes_state_field(input aes_dma_st_e st, input logic op);
    if (st == StIdle) begin
      return AES_STATE_IDLE;
    end
    return (op == AES_OP_DECRYPT) ? AES_STATE_DECRYPTING : AES_STATE_ENCRYPTING;
  endfunction

endpackage

// File: rtl/aes_blk_buf.sv
// 16-byte AES block buffer.
//   clk, rst     : clock, asynchronous active-high reset (clears the buffer)
//   wr_en_i      : write wr_byte_i into byte lane wr_idx_i
//   ld_en_i      : parallel load of ld_data_i (wins over a byte write)
//   rd_idx_i     : byte lane presented on rd_byte_o
//   data_o       : full 128-bit contents, byte 0 in bits [7:0]
module aes_blk_buf
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [3:0]   wr_idx_i,
  input  logic [7:0]   wr_byte_i,
  input  logic         ld_en_i,
  input  logic [127:0] ld_data_i,
  input  logic [3:0]   rd_idx_i,
  output logic [7:0]   rd_byte_o,
  output logic [127:0] data_o
);

  localparam int unsigned Width = AES_BLK_BYTES * 8;

  logic [Width-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (ld_en_i) begin
      data_d = ld_data_i;
    end else if (wr_en_i) begin
      data_d[{wr_idx_i, 3'b000} +: 8] = wr_byte_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_byte_o = data_q[{rd_idx_i, 3'b000} +: 8];
  assign data_o    = data_q;

endmodule

// File: rtl/aes_dma_ctrl.sv
// AES DMA sequencer. On start it walks XRAM from opaddr in 16-byte blocks
// (oplen[15:4] blocks, trailing partial block ignored): reads a block over the
// XRAM master port, runs it through the AES core and writes the result back
// in place.
//   clk, rst          : clock, asynchronous active-high reset
//   start/op/opaddr/oplen : operation request, sampled on start in IDLE
//   state, done       : STATE field (0 idle, 1 encrypting, 2 decrypting), done pulse
//   xm_*              : XRAM master (stb/wr/addr/wdata out, ack/rdata in)
//   core_*            : AES core handshake (start pulse, direction, block in/out)
// All outputs are registered.
module aes_dma_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned BLK_BYTES = 16,
  parameter int unsigned AW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] opaddr,
  input  logic [15:0]   oplen,
  output logic [1:0]    state,
  output logic          done,
  output logic [AW-1:0] xm_addr,
  output logic [7:0]    xm_wdata,
  output logic          xm_wr,
  output logic          xm_stb,
  input  logic          xm_ack,
  input  logic [7:0]    xm_rdata,
  output logic          core_start,
  output logic          core_dec,
  output logic [127:0]  core_in,
  input  logic [127:0]  core_out,
  input  logic          core_done
);

  aes_dma_st_e   st_q, st_d;
  logic          op_q, op_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [11:0]   nblk_q, nblk_d;
  logic [3:0]    bc_q, bc_d;

  logic [1:0]    state_q, state_d;
  logic          done_q, done_d;
  logic [AW-1:0] xm_addr_q, xm_addr_d;
  logic [7:0]    xm_wdata_q, xm_wdata_d;
  logic          xm_wr_q, xm_wr_d;
  logic          xm_stb_q, xm_stb_d;
  logic          core_start_q, core_start_d;
  logic          core_dec_q, core_dec_d;

  logic          ack;
  logic          in_wr, in_clr, res_ld;
  logic [7:0]    res_rd_byte;
  logic [7:0]    unused_in_rd_byte;
  logic [127:0]  unused_res_data;

  // Acks are only meaningful while the strobe is actually up.
  assign ack = xm_ack & xm_stb_q;

  aes_blk_buf u_in_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_wr),
    .wr_idx_i  (bc_q),
    .wr_byte_i (xm_rdata),
    .ld_en_i   (in_clr),
    .ld_data_i ('0),
    .rd_idx_i  (4'd0),
    .rd_byte_o (unused_in_rd_byte),
    .data_o    (core_in)
  );

  aes_blk_buf u_res_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (1'b0),
    .wr_idx_i  (4'd0),
    .wr_byte_i (8'd0),
    .ld_en_i   (res_ld),
    .ld_data_i (core_out),
    .rd_idx_i  (bc_d),
    .rd_byte_o (res_rd_byte),
    .data_o    (unused_res_data)
  );

  always_comb begin
    st_d         = st_q;
    op_d         = op_q;
    ptr_d        = ptr_q;
    nblk_d       = nblk_q;
    bc_d         = bc_q;
    in_wr        = 1'b0;
    in_clr       = 1'b0;
    res_ld       = 1'b0;
    done_d       = 1'b0;
    core_start_d = 1'b0;

    unique case (st_q)
      StIdle: begin
        if (start) begin
          op_d   = op;
          ptr_d  = opaddr;
          nblk_d = oplen[15:4];
          bc_d   = 4'd0;
          in_clr = 1'b1;
          st_d   = (oplen[15:4] == 12'd0) ? StFin : StRd;
        end
      end
      StRd: begin
        if (ack) begin
          in_wr = 1'b1;
          if (bc_q == 4'hf) begin
            bc_d         = 4'd0;
            core_start_d = 1'b1;
            st_d         = StCrypt;
          end else begin
            bc_d = bc_q + 4'd1;
          end
        end
      end
      StCrypt: begin
        if (core_done) begin
          res_ld = 1'b1;
          bc_d   = 4'd0;
          st_d   = StWr;
        end
      end
      StWr: begin
        if (ack) begin
          if (bc_q == 4'hf) begin
            bc_d   = 4'd0;
            ptr_d  = ptr_q + AW'(BLK_BYTES);
            nblk_d = nblk_q - 12'd1;
            st_d   = (nblk_q == 12'd1) ? StFin : StRd;
          end else begin
            bc_d = bc_q + 4'd1;
          end
        end
      end
      StFin: begin
        done_d = 1'b1;
        st_d   = StIdle;
      end
      default: st_d = StIdle;
    endcase

    // Registered bus outputs are computed from the next-state values so they
    // line up with the state the FSM is entering.
    xm_stb_d  = (st_d == StRd) || (st_d == StWr);
    xm_wr_d   = (st_d == StWr);
    xm_addr_d = xm_stb_d ? (ptr_d + AW'(bc_d)) : xm_addr_q;

    // Byte 0 of a fresh result is taken straight from the core since the
    // result buffer only loads on this same edge.
    xm_wdata_d = xm_wdata_q;
    if (st_d == StWr) begin
      xm_wdata_d = res_ld ? core_out[7:0] : res_rd_byte;
    end

    state_d    = aes_state_field(st_d, op_d);
    core_dec_d = op_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= StIdle;
      op_q         <= 1'b0;
      ptr_q        <= '0;
      nblk_q       <= '0;
      bc_q         <= '0;
      state_q      <= AES_STATE_IDLE;
      done_q       <= 1'b0;
      xm_addr_q    <= '0;
      xm_wdata_q   <= '0;
      xm_wr_q      <= 1'b0;
      xm_stb_q     <= 1'b0;
      core_start_q <= 1'b0;
      core_dec_q   <= 1'b0;
    end else begin
      st_q         <= st_d;
      op_q         <= op_d;
      ptr_q        <= ptr_d;
      nblk_q       <= nblk_d;
      bc_q         <= bc_d;
      state_q      <= state_d;
      done_q       <= done_d;
      xm_addr_q    <= xm_addr_d;
      xm_wdata_q   <= xm_wdata_d;
      xm_wr_q      <= xm_wr_d;
      xm_stb_q     <= xm_stb_d;
      core_start_q <= core_start_d;
      core_dec_q   <= core_dec_d;
    end
  end

  assign state      = state_q;
  assign done       = done_q;
  assign xm_addr    = xm_addr_q;
  assign xm_wdata   = xm_wdata_q;
  assign xm_wr      = xm_wr_q;
  assign xm_stb     = xm_stb_q;
  assign core_start = core_start_q;
  assign core_dec   = core_dec_q;

endmodule

// File: tb/tb_aes_dma_ctrl.sv
// Scoreboard bench for aes_dma_ctrl: stimulus pushes expected XRAM transfers,
// core requests and done pulses; a monitor pops and compares them.
module tb_aes_dma_ctrl;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [1:0]  st;
  } xact_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [15:0]  opaddr = '0;
  logic [15:0]  oplen = '0;
  logic [1:0]   state;
  logic         done;
  logic [15:0]  xm_addr;
  logic [7:0]   xm_wdata;
  logic         xm_wr;
  logic         xm_stb;
  logic         xm_ack = 1'b0;
  logic [7:0]   xm_rdata = '0;
  logic         core_start;
  logic         core_dec;
  logic [127:0] core_in;
  logic [127:0] core_out = '0;
  logic         core_done = 1'b0;

  aes_dma_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .opaddr     (opaddr),
    .oplen      (oplen),
    .state      (state),
    .done       (done),
    .xm_addr    (xm_addr),
    .xm_wdata   (xm_wdata),
    .xm_wr      (xm_wr),
    .xm_stb     (xm_stb),
    .xm_ack     (xm_ack),
    .xm_rdata   (xm_rdata),
    .core_start (core_start),
    .core_dec   (core_dec),
    .core_in    (core_in),
    .core_out   (core_out),
    .core_done  (core_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;
  int done_exp = 0;
  int max_dly = 0;
  bit spur_ack = 1'b0;
  bit spur_done = 1'b0;

  xact_t         xq[$];
  logic [128:0]  cq[$];
  logic [7:0]    mem     [0:65535];
  logic [7:0]    exp_mem [0:65535];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // XRAM model: evaluated mid-cycle, ack after 0..max_dly wait cycles.
  initial begin : mem_model
    int wait_c;
    wait_c = 0;
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
    forever begin
      @(negedge clk);
      if (xm_stb) begin
        if (wait_c == 0) begin
          xm_ack = 1'b1;
          if (xm_wr) mem[xm_addr] = xm_wdata;
          else xm_rdata = mem[xm_addr];
          wait_c = $urandom_range(0, max_dly);
        end else begin
          xm_ack = 1'b0;
          wait_c--;
        end
      end else begin
        xm_ack   = spur_ack;
        xm_rdata = 8'($urandom());
      end
    end
  end

  // Core stub: result = input ^ all-ones, core_done 3 cycles after core_start.
  initial begin : core_stub
    bit           busy;
    int           cnt;
    logic [127:0] lat;
    busy = 1'b0;
    cnt  = 0;
    lat  = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (busy) begin
        if (cnt == 1) begin
          core_done = 1'b1;
          core_out  = ~lat;
          busy      = 1'b0;
        end else begin
          cnt--;
        end
      end else if (core_start) begin
        busy = 1'b1;
        cnt  = 3;
        lat  = core_in;
      end else if (spur_done && $urandom_range(0, 5) == 0) begin
        core_done = 1'b1;
        core_out  = {4{$urandom()}};
      end
    end
  end

  // Monitor: compares every accepted transfer, core request and done pulse.
  initial begin : monitor
    xact_t        e, a;
    logic [128:0] c;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && xm_stb && xm_ack) begin
        a = '{wr: xm_wr, addr: xm_addr, data: xm_wr ? xm_wdata : 8'h00, st: state};
        if (xq.size() == 0) begin
          chk("unexpected xfer", {128'd0, a}, '0);
        end else begin
          e = xq.pop_front();
          chk("xfer", {128'd0, a}, {128'd0, e});
        end
      end
      if (!rst && core_start) begin
        if (cq.size() == 0) begin
          chk("unexpected core_start", {31'd0, core_dec, core_in}, '0);
        end else begin
          c = cq.pop_front();
          chk("core_start dec/in", {31'd0, core_dec, core_in}, {31'd0, c});
        end
      end
      if (!rst && done) begin
        done_seen++;
        if (done_seen > done_exp) chk("unexpected done", 160'(done_seen), 160'(done_exp));
      end
    end
  end

  task automatic push_exp(input logic o, input logic [15:0] base, input logic [15:0] len);
    logic [15:0]  a;
    logic [127:0] blk;
    logic [1:0]   st;
    st = o ? 2'd2 : 2'd1;
    for (int b = 0; b < int'(len[15:4]); b++) begin
      blk = '0;
      for (int i = 0; i < 16; i++) begin
        a = base + 16'(b * 16 + i);
        blk[i*8 +: 8] = exp_mem[a];
        xq.push_back('{wr: 1'b0, addr: a, data: 8'h00, st: st});
      end
      cq.push_back({o, blk});
      for (int i = 0; i < 16; i++) begin
        a = base + 16'(b * 16 + i);
        exp_mem[a] = ~exp_mem[a];
        xq.push_back('{wr: 1'b1, addr: a, data: exp_mem[a], st: st});
      end
    end
  endtask

  task automatic pulse_start(input logic o, input logic [15:0] base, input logic [15:0] len);
    start  = 1'b1;
    op     = o;
    opaddr = base;
    oplen  = len;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_seen < done_exp && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_seen < done_exp) chk({name, " done timeout"}, 160'(done_seen), 160'(done_exp));
    repeat (3) @(posedge clk);
    #1;
    chk({name, " done count"}, 160'(done_seen), 160'(done_exp));
    chk({name, " xfers left"}, 160'(xq.size()), 160'd0);
    chk({name, " core reqs left"}, 160'(cq.size()), 160'd0);
    chk({name, " state idle"}, 160'(state), 160'd0);
  endtask

  task automatic run_op(input string name, input logic o, input logic [15:0] base,
                        input logic [15:0] len);
    push_exp(o, base, len);
    done_exp++;
    pulse_start(o, base, len);
    wait_done(name);
  endtask

  initial begin : stim
    bit found;
    for (int i = 0; i < 65536; i++) exp_mem[i] = pat(16'(i));

    #1;
    chk("reset state", 160'(state), 160'd0);
    chk("reset stb/wr/done/cs/dec", {155'd0, xm_stb, xm_wr, done, core_start, core_dec}, '0);
    chk("reset addr/wdata", {136'd0, xm_addr, xm_wdata}, '0);
    chk("reset core_in", {32'd0, core_in}, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single encrypt block; ack held high even when no strobe is up.
    spur_ack = 1'b1;
    run_op("enc 1blk", 1'b0, 16'h0100, 16'h0010);
    spur_ack = 1'b0;

    // Decrypt, length with a partial trailing block.
    run_op("dec 2blk", 1'b1, 16'h0200, 16'h0023);
    chk("byte 0x220 untouched", 160'(mem[16'h0220]), 160'(pat(16'h0220)));
    chk("core_dec held", 160'(core_dec), 160'd1);

    // Address wrap at ffff.
    run_op("wrap", 1'b0, 16'hfff8, 16'h0010);

    // Random ack delays, spurious core_done, second start mid-operation.
    max_dly   = 5;
    spur_done = 1'b1;
    push_exp(1'b0, 16'h0400, 16'h0020);
    done_exp++;
    pulse_start(1'b0, 16'h0400, 16'h0020);
    repeat (20) @(posedge clk);
    #1;
    pulse_start(1'b1, 16'h0800, 16'h0040);
    wait_done("delays+restart");
    max_dly   = 0;
    spur_done = 1'b0;

    // Reset during the write pass at byte 7.
    push_exp(1'b1, 16'h0600, 16'h0020);
    pulse_start(1'b1, 16'h0600, 16'h0020);
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(posedge clk);
      #1;
      if (xm_stb && xm_wr && xm_addr == 16'h0607) found = 1'b1;
    end
    chk("reached WR bc=7", 160'(found), 160'd1);
    rst = 1'b1;
    #1;
    chk("rst mid-op stb", 160'(xm_stb), 160'd0);
    chk("rst mid-op state", 160'(state), 160'd0);
    xq.delete();
    cq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no done after rst", 160'(done_seen), 160'(done_exp));
    run_op("after rst", 1'b0, 16'h0700, 16'h0010);

    // Zero blocks: no traffic, done two cycles after start.
    done_exp++;
    start  = 1'b1;
    op     = 1'b1;
    opaddr = 16'h0900;
    oplen  = 16'h000f;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("nblk0 done t+1", 160'(done), 160'd0);
    @(posedge clk);
    #1;
    chk("nblk0 done t+2", 160'(done), 160'd1);
    wait_done("nblk0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/aes_dma_ctrl.md
Name: aes_dma_ctrl

Overview:
Sequencer for the memory-mapped AES unit. When firmware writes the op register, this block walks XRAM from OPADDR for OPLEN bytes in 16-byte blocks. For each block it reads 16 bytes over the oc8051_xram-style master port, runs the AES core, and writes the result back in place. It drives the STATE register field read back by firmware.

Parameters:
BLK_BYTES, 16, bytes per AES block; fixed and must remain 16.
AW, 16, XRAM address width.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse from the op register write decode
op  in  1  0 = encrypt, 1 = decrypt; sampled on start
opaddr  in  16  base XRAM address; sampled on start
oplen  in  16  length in bytes; sampled on start
state  out  2  0 = IDLE, 1 = ENCRYPTING, 2 = DECRYPTING
done  out  1  one-cycle pulse when the operation completes
xm_addr  out  16  XRAM master address
xm_wdata  out  8  XRAM write data
xm_wr  out  1  write enable, qualified by xm_stb
xm_stb  out  1  strobe
xm_ack  in  1  XRAM acknowledge
xm_rdata  in  8  XRAM read data
core_start  out  1  one-cycle pulse to the AES core
core_dec  out  1  core direction
core_in  out  128  block to the core
core_out  in  128  core result
core_done  in  1  one-cycle pulse; core_out valid in the same cycle

Reset and clock: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Reset state: FSM IDLE; state=0, done=0, xm_stb=0, xm_wr=0, xm_addr=0, xm_wdata=0, core_start=0, core_dec=0, core_in=0; all counters 0.
- FSM states: IDLE, RD, CRYPT, WR, FIN.
- IDLE:
  - On start, latch op, opaddr and nblk = oplen[15:4]. oplen[3:0] is ignored (partial blocks are not processed).
  - If nblk==0, go to FIN. Otherwise go to RD with ptr=opaddr and byte counter bc=0.
- RD:
  - xm_stb=1, xm_wr=0, xm_addr = ptr + bc (16-bit, wraps ffff->0000).
  - On xm_ack, capture xm_rdata into core_in[8*bc+7 : 8*bc] and increment bc.
  - xm_stb stays high between bytes; xm_addr updates the cycle after ack.
  - After the ack for bc=15, pulse core_start for one cycle and go to CRYPT.
- CRYPT:
  - xm_stb=0. Wait for core_done, then latch core_out into the result buffer, set bc=0 and go to WR.
  - core_dec=op, held throughout the operation.
- WR:
  - xm_stb=1, xm_wr=1, xm_addr = ptr + bc, xm_wdata = result[8*bc+7 : 8*bc]; advance on xm_ack.
  - After the ack for bc=15: ptr += 16 (wraps), nblk -= 1, bc=0.
  - If nblk was 1, go to FIN; otherwise go to RD.
- FIN: pulse done for one cycle, then go to IDLE.
- state output: 0 in IDLE; otherwise 1 when the latched op is encrypt, 2 when decrypt.
- Busy rules:
  - start while not IDLE is ignored; latched parameters do not change.
  - start in the same cycle as the FIN->IDLE transition is ignored.
  - core_done outside CRYPT is ignored.
  - xm_ack while xm_stb=0 is ignored.
- Throughput: each byte costs at least one cycle, and ack may arrive in the same cycle stb rises. Per-block minimum is 16 + 1 + core latency + 16 cycles.
- Reset mid-operation:
  - Immediate return to IDLE with xm_stb=0; no done pulse.
  - Partially written blocks remain in XRAM; this is accepted.

Decomposition:
- Shared package aes_pkg holds:
  - register addresses (KEY00..KEY07 ff00-ff0e, OP ff80, STATE ff82, OPADDR ff84, OPLEN ff86);
  - AES_OP_ENCRYPT/DECRYPT;
  - AES_STATE_IDLE/ENCRYPTING/DECRYPTING;
  - the local FSM encodings.
- One sub-module, aes_blk_buf: a 16-byte shift/index buffer with byte write by index and 128-bit parallel load/read. It is instantiated twice, once for the input block and once for the result block.

Test Plan:
- oplen=16, opaddr=0x0100, op=0, memory model acks every cycle, core stub XORs with 0xFF..FF after 3 cycles. Required: 16 reads at 0x0100-0x010F, one core_start, 16 writes of inverted bytes, done exactly once, state 1 during the operation and 0 after.
- oplen=0x0023, op=1. Required: exactly 2 blocks processed (0x20 bytes), byte 0x20 untouched, state=2 while busy, core_dec=1.
- opaddr=0xFFF8, oplen=16. Required: addresses FFF8..FFFF then 0000..0007 for both the read and the write passes.
- Random ack delays of 0-5 cycles, plus a second start pulse mid-operation with different opaddr. Required: second start ignored; output identical to the no-delay run.
- rst asserted during WR at bc=7. Required: xm_stb=0 and state=0 in the same cycle, no done pulse; a new start afterwards completes normally.
- oplen=0x000F. Required: no XRAM traffic, no core_start, done pulses 2 cycles after start.
